// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: shared constants and types for the memory-stage load/store unit.
//   - RV32 opcodes for LOAD/STORE
//   - funct3 encodings for every legal load/store width
//   - FSM state encoding used by lsu_mem
package lsu_mem_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_align.sv
// lsu_mem_align: combinational lane logic for the load/store unit.
// Ports:
//   i_is_store   1 = store, 0 = load (selects which funct3 values are legal)
//   i_funct3     access width / signedness
//   i_offset     byte offset addr[1:0]
//   i_store_data rs2 value to be lane-replicated
//   i_rdata      raw memory word for load extraction
//   o_be         byte enables (all ones for loads)
//   o_wdata      lane-aligned store data
//   o_load_data  extracted and extended load result
//   o_fault      misaligned access or illegal funct3
module lsu_mem_align
  import lsu_mem_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_fault
);

  logic [31:0] w_shift;
  logic        w_illegal;
  logic        w_misaligned;

  // Bring the addressed byte/halfword down to bit 0.
  assign w_shift = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_store_data;
    o_load_data  = '0;

    if (i_is_store) begin
      w_illegal = !(i_funct3 == F3_SB || i_funct3 == F3_SH || i_funct3 == F3_SW);
    end else begin
      w_illegal = !(i_funct3 == F3_LB || i_funct3 == F3_LH || i_funct3 == F3_LW ||
                    i_funct3 == F3_LBU || i_funct3 == F3_LHU);
    end

    // funct3[1:0] encodes the size for both loads and stores.
    case (i_funct3[1:0])
      2'b01:   w_misaligned = i_offset[0];
      2'b10:   w_misaligned = (i_offset != 2'b00);
      default: w_misaligned = 1'b0;
    endcase

    if (i_is_store) begin
      case (i_funct3)
        F3_SB: begin
          o_be    = 4'b0001 << i_offset;
          o_wdata = {4{i_store_data[7:0]}};
        end
        F3_SH: begin
          o_be    = 4'b0011 << i_offset;
          o_wdata = {2{i_store_data[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_store_data;
        end
      endcase
    end

    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LW:   o_load_data = w_shift;
      F3_LBU:  o_load_data = {24'd0, w_shift[7:0]};
      F3_LHU:  o_load_data = {16'd0, w_shift[15:0]};
      default: o_load_data = '0;
    endcase

    o_fault = w_illegal | w_misaligned;
  end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: memory-stage load/store unit.
// Accepts one execute-stage result at a time, issues a valid/ready data-memory
// request for loads/stores, and emits a one-cycle writeback record.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid_i / req_ready_o          upstream handshake (ready only in IDLE)
//   opcode_i, funct3_i, addr_i,
//   store_data_i, rd_i                 captured instruction fields
//   dmem_req_valid_o / dmem_req_ready_i memory request handshake
//   dmem_addr_o, dmem_we_o, dmem_be_o,
//   dmem_wdata_o                       request payload, stable while pending
//   dmem_rsp_valid_i, dmem_rdata_i     load response (only honoured in WAIT)
//   wb_valid_o, wb_data_o, wb_rd_o,
//   wb_we_o, fault_o                   writeback record
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] store_data_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic              dmem_rsp_valid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_we_o,
  output logic              fault_o
);

  lsu_state_e        r_state;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_is_store;
  logic              r_dmem_req_valid;
  logic [AWIDTH-1:0] r_dmem_addr;
  logic              r_dmem_we;
  logic [3:0]        r_dmem_be;
  logic [DWIDTH-1:0] r_dmem_wdata;
  logic              r_wb_valid;
  logic [DWIDTH-1:0] r_wb_data;
  logic [4:0]        r_wb_rd;
  logic              r_wb_we;
  logic              r_fault;

  logic              w_is_store_in;
  logic              w_is_mem_in;
  logic              w_idle;
  logic [2:0]        w_sel_funct3;
  logic [1:0]        w_sel_off;
  logic              w_sel_store;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;
  logic              w_fault;

  assign w_idle        = (r_state == IDLE);
  assign w_is_store_in = (opcode_i == OPCODE_STORE);
  assign w_is_mem_in   = w_is_store_in || (opcode_i == OPCODE_LOAD);

  // One align instance serves both phases: live inputs while deciding at
  // accept time, captured fields afterwards for load extraction.
  assign w_sel_funct3 = w_idle ? funct3_i      : r_funct3;
  assign w_sel_off    = w_idle ? addr_i[1:0]   : r_off;
  assign w_sel_store  = w_idle ? w_is_store_in : r_is_store;

  lsu_mem_align u_align (
    .i_is_store   (w_sel_store),
    .i_funct3     (w_sel_funct3),
    .i_offset     (w_sel_off),
    .i_store_data (store_data_i),
    .i_rdata      (dmem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_fault      (w_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_funct3         <= '0;
      r_off            <= '0;
      r_is_store       <= 1'b0;
      r_dmem_req_valid <= 1'b0;
      r_dmem_addr      <= '0;
      r_dmem_we        <= 1'b0;
      r_dmem_be        <= '0;
      r_dmem_wdata     <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_data        <= '0;
      r_wb_rd          <= '0;
      r_wb_we          <= 1'b0;
      r_fault          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_funct3   <= funct3_i;
            r_off      <= addr_i[1:0];
            r_is_store <= w_is_store_in;
            r_wb_rd    <= rd_i;
            if (w_is_mem_in && w_fault) begin
              // Faulting access completes immediately, memory untouched.
              r_state    <= DONE;
              r_wb_valid <= 1'b1;
              r_wb_data  <= '0;
              r_wb_we    <= 1'b0;
              r_fault    <= 1'b1;
            end else if (w_is_mem_in) begin
              r_state          <= REQ;
              r_dmem_req_valid <= 1'b1;
              r_dmem_addr      <= {addr_i[AWIDTH-1:2], 2'b00};
              r_dmem_we        <= w_is_store_in;
              r_dmem_be        <= w_be;
              r_dmem_wdata     <= w_is_store_in ? DWIDTH'(w_wdata) : '0;
            end else begin
              r_state    <= DONE;
              r_wb_valid <= 1'b1;
              r_wb_data  <= DWIDTH'(addr_i);
              r_wb_we    <= (rd_i != 5'd0);
              r_fault    <= 1'b0;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready_i) begin
            r_dmem_req_valid <= 1'b0;
            if (r_is_store) begin
              r_state    <= DONE;
              r_wb_valid <= 1'b1;
              r_wb_data  <= '0;
              r_wb_we    <= 1'b0;
              r_fault    <= 1'b0;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rsp_valid_i) begin
            r_state    <= DONE;
            r_wb_valid <= 1'b1;
            r_wb_data  <= DWIDTH'(w_load_data);
            r_wb_we    <= (r_wb_rd != 5'd0);
            r_fault    <= 1'b0;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_wb_valid <= 1'b0;
          r_wb_we    <= 1'b0;
          r_fault    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o      = w_idle && !reset;
  assign dmem_req_valid_o = r_dmem_req_valid;
  assign dmem_addr_o      = r_dmem_addr;
  assign dmem_we_o        = r_dmem_we;
  assign dmem_be_o        = r_dmem_be;
  assign dmem_wdata_o     = r_dmem_wdata;
  assign wb_valid_o       = r_wb_valid;
  assign wb_data_o        = r_wb_data;
  assign wb_rd_o          = r_wb_rd;
  assign wb_we_o          = r_wb_we;
  assign fault_o          = r_fault;

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: randomized and directed checks of lsu_mem against a behavioural
// model that derives byte enables, lane data and load results arithmetically.
module tb_lsu_mem;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rsp_valid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic        fault_o;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] last_wb_data;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic        last_we;

  always #5 clk = ~clk;

  lsu_mem #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .opcode_i         (opcode_i),
    .funct3_i         (funct3_i),
    .addr_i           (addr_i),
    .store_data_i     (store_data_i),
    .rd_i             (rd_i),
    .dmem_req_valid_o (dmem_req_valid_o),
    .dmem_req_ready_i (dmem_req_ready_i),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_rsp_valid_i (dmem_rsp_valid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_data_o        (wb_data_o),
    .wb_rd_o          (wb_rd_o),
    .wb_we_o          (wb_we_o),
    .fault_o          (fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: access size in bytes, enables as a run of ones,
  // replicated lanes by byte index modulo size, loads via integer arithmetic.
  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata, input logic [4:0] rd,
                       output bit mem, output bit fault, output logic [3:0] be,
                       output logic [31:0] wdata, output logic [31:0] wbd, output bit wbwe);
    int unsigned nbytes;
    int unsigned off;
    bit is_ld, is_st, legal;
    longint unsigned v;
    is_ld  = (op == OP_LOAD);
    is_st  = (op == OP_STORE);
    mem    = is_ld || is_st;
    off    = addr % 4;
    nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal  = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    fault  = mem && (!legal || (off % nbytes != 0));
    be     = 4'hF;
    wdata  = sdata;
    wbd    = 32'd0;
    wbwe   = 1'b0;
    if (!mem) begin
      wbd  = addr;
      wbwe = (rd != 0);
    end else if (!fault && is_st) begin
      be = 4'(((1 << nbytes) - 1) << off);
      for (int i = 0; i < 4; i++) wdata[8*i +: 8] = sdata[8*(i % nbytes) +: 8];
    end else if (!fault && is_ld) begin
      v = (longint'(rdata) / (64'd1 << (8 * off))) % (64'd1 << (8 * nbytes));
      if (f3 < 4 && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
        v = v + 64'hFFFF_FFFF_0000_0000 - (64'd1 << (8 * nbytes)) + 64'h1_0000_0000;
      wbd  = v[31:0];
      wbwe = (rd != 0);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, idle again.
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input logic [4:0] rd,
                         input int rdy_dly, input int rsp_dly);
    bit mem, fault, wbwe;
    logic [3:0]  be;
    logic [31:0] wdata, wbd;
    int lat;
    model(op, f3, addr, sdata, rdata, rd, mem, fault, be, wdata, wbd, wbwe);
    chk("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    opcode_i     = op;
    funct3_i     = f3;
    addr_i       = addr;
    store_data_i = sdata;
    rd_i         = rd;
    @(negedge clk);
    lat = 1;
    req_valid_i  = 1'b0;
    addr_i       = $urandom;
    store_data_i = $urandom;
    funct3_i     = 3'($urandom);
    rd_i         = 5'($urandom);
    if (mem && !fault) begin
      for (int c = 0; c <= rdy_dly; c++) begin
        chk("req_valid", 32'(dmem_req_valid_o), 32'd1);
        chk("req_addr", dmem_addr_o, {addr[31:2], 2'b00});
        chk("req_we", 32'(dmem_we_o), 32'(op == OP_STORE));
        chk("req_be", 32'(dmem_be_o), 32'(be));
        if (op == OP_STORE) chk("req_wdata", dmem_wdata_o, wdata);
        chk("busy_ready", 32'(req_ready_o), 32'd0);
        chk("early_wb", 32'(wb_valid_o), 32'd0);
        last_be    = dmem_be_o;
        last_wdata = dmem_wdata_o;
        last_we    = dmem_we_o;
        dmem_req_ready_i = (c == rdy_dly);
        @(negedge clk);
        lat++;
      end
      dmem_req_ready_i = 1'b0;
      if (op == OP_LOAD) begin
        for (int c = 0; c <= rsp_dly; c++) begin
          chk("wait_novalid", 32'(dmem_req_valid_o), 32'd0);
          chk("wait_nowb", 32'(wb_valid_o), 32'd0);
          if (c == rsp_dly) begin
            dmem_rsp_valid_i = 1'b1;
            dmem_rdata_i     = rdata;
          end
          @(negedge clk);
          lat++;
        end
        dmem_rsp_valid_i = 1'b0;
        dmem_rdata_i     = $urandom;
      end
    end else begin
      chk("no_req", 32'(dmem_req_valid_o), 32'd0);
    end
    chk("wb_valid", 32'(wb_valid_o), 32'd1);
    chk("wb_data", wb_data_o, wbd);
    chk("wb_rd", 32'(wb_rd_o), 32'(rd));
    chk("wb_we", 32'(wb_we_o), 32'(wbwe));
    chk("fault", 32'(fault_o), 32'(fault));
    chk("done_ready", 32'(req_ready_o), 32'd0);
    last_wb_data = wb_data_o;
    $display("txn op=%02h f3=%0d addr=%08h rd=%0d lat=%0d wb=%08h we=%0b fault=%0b",
             op, f3, addr, rd, lat, wb_data_o, wb_we_o, fault_o);
    @(negedge clk);
    chk("wb_pulse", 32'(wb_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    req_valid_i      = 1'b0;
    opcode_i         = '0;
    funct3_i         = '0;
    addr_i           = '0;
    store_data_i     = '0;
    rd_i             = '0;
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rdata_i     = '0;
    last_wb_data     = '0;
    last_be          = '0;
    last_wdata       = '0;
    last_we          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_req_valid", 32'(dmem_req_valid_o), 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_txn(OP_LOAD, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 5'd7, 0, 0);
    chk("lb_data", last_wb_data, 32'hFFFF_FF80);
    chk("lb_be", 32'(last_be), 32'hF);
    run_txn(OP_STORE, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 5'd9, 0, 0);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(last_we), 32'd1);
    run_txn(OP_LOAD, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 5'd4, 0, 0);
    run_txn(OP_LOAD, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 5'd4, 0, 0);
    run_txn(OP_LOAD, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_0000, 5'd2, 3, 2);
    chk("lhu_data", last_wb_data, 32'h0000_8001);
    run_txn(OP_ALU, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 5'd5, 0, 0);
    chk("alu_data", last_wb_data, 32'h0000_0042);
    run_txn(OP_ALU, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 5'd0, 0, 0);
    run_txn(OP_STORE, 3'b011, 32'h0000_5000, 32'h1234, 32'h0, 5'd1, 0, 0);
    run_txn(OP_STORE, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0, 5'd1, 1, 0);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);

    // Reset while waiting for a load response, then a stale response.
    req_valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b010;
    addr_i = 32'h0000_6000; rd_i = 5'd3;
    @(negedge clk);
    req_valid_i = 1'b0;
    dmem_req_ready_i = 1'b1;
    @(negedge clk);
    dmem_req_ready_i = 1'b0;
    chk("wait_req_low", 32'(dmem_req_valid_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy_ready", 32'(req_ready_o), 32'd0);
    chk("rst_wait_wb", 32'(wb_valid_o), 32'd0);
    reset = 1'b0;
    dmem_rsp_valid_i = 1'b1;
    dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);
    chk("post_rst_req", 32'(dmem_req_valid_o), 32'd0);
    @(negedge clk);
    dmem_rsp_valid_i = 1'b0;
    chk("stale_wb0", 32'(wb_valid_o), 32'd0);
    @(negedge clk);
    chk("stale_wb1", 32'(wb_valid_o), 32'd0);
    run_txn(OP_LOAD, 3'b010, 32'h0000_6004, 32'h0, 32'h1357_9BDF, 5'd3, 0, 1);

    // Reset while the request is pending.
    req_valid_i = 1'b1; opcode_i = OP_STORE; funct3_i = 3'b010;
    addr_i = 32'h0000_7000; store_data_i = 32'h55AA_55AA; rd_i = 5'd0;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("req_pending", 32'(dmem_req_valid_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_drop", 32'(dmem_req_valid_o), 32'd0);
    chk("rst_req_nowb", 32'(wb_valid_o), 32'd0);
    @(negedge clk);
    chk("rst_req_nowb2", 32'(wb_valid_o), 32'd0);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic [6:0]  op;
      logic [4:0]  rd;
      case ($urandom_range(0, 5))
        0, 1:    op = OP_LOAD;
        2, 3:    op = OP_STORE;
        4:       op = OP_ALU;
        default: op = 7'($urandom);
      endcase
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_txn(op, 3'($urandom), $urandom, $urandom, $urandom, rd,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
